// File: rtl/motor_pkg.sv
// Shared definitions for the motor fault monitor: FSM encoding, fault codes
// and default parameter values.
package motor_pkg;

    localparam int DEF_N_CH     = 2;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_AVG_LOG2 = 2;
    localparam int DEF_DEB_CNT  = 3;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'b00,
        ST_PENDING = 2'b01,
        ST_FAULT   = 2'b10
    } chan_state_t;

    localparam logic [1:0] CODE_NONE        = 2'b00;
    localparam logic [1:0] CODE_OVERCURRENT = 2'b01;
    localparam logic [1:0] CODE_STALL       = 2'b10;
    localparam logic [1:0] CODE_OVERSPEED   = 2'b11;

endpackage

// File: rtl/motor_fault_monitor_if.sv
// Sample bus carrying per-channel current and speed from the sensing front end.
interface motor_sample_if #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 16
);
    logic                     sample_valid;
    logic [N_CH*DATA_W-1:0]   current_in;
    logic [N_CH*DATA_W-1:0]   speed_in;

    modport master (output sample_valid, current_in, speed_in);
    modport slave  (input  sample_valid, current_in, speed_in);
endinterface

// File: rtl/motor_fault_chan.sv
// One motor channel: classifies each window average and debounces violations
// into a sticky, clearable fault.
module motor_fault_chan
    import motor_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEB_CNT = DEF_DEB_CNT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              avg_valid,
    input  logic [DATA_W-1:0] avg_i,
    input  logic [DATA_W-1:0] avg_s,
    input  logic [DATA_W-1:0] i_max,
    input  logic [DATA_W-1:0] i_stall,
    input  logic [DATA_W-1:0] spd_min,
    input  logic [DATA_W-1:0] spd_max,
    input  logic              fault_clr,
    output logic              fault_detected,
    output logic [1:0]        fault_code
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_CNT);

    chan_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  code_q, code_d;
    logic [1:0]  viol_code;
    logic [7:0]  cnt_inc;

    // Highest-priority violation wins; CODE_NONE means the average is healthy.
    always_comb begin
        viol_code = CODE_NONE;
        if (avg_i > i_max)
            viol_code = CODE_OVERCURRENT;
        else if ((avg_i > i_stall) && (avg_s < spd_min))
            viol_code = CODE_STALL;
        else if (avg_s > spd_max)
            viol_code = CODE_OVERSPEED;
    end

    assign cnt_inc = cnt_q + 8'd1;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        if (fault_clr) begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
            code_d  = CODE_NONE;
        end else if (avg_valid) begin
            case (state_q)
                ST_NORMAL: begin
                    if (viol_code != CODE_NONE) begin
                        if (DEB_CNT == 1) begin
                            state_d = ST_FAULT;
                            code_d  = viol_code;
                        end else begin
                            state_d = ST_PENDING;
                        end
                        cnt_d = 8'd1;
                    end
                end
                ST_PENDING: begin
                    if (viol_code != CODE_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB_LAST) begin
                            state_d = ST_FAULT;
                            code_d  = viol_code;
                        end
                    end else begin
                        state_d = ST_NORMAL;
                        cnt_d   = '0;
                    end
                end
                ST_FAULT: ;
                default: begin
                    state_d = ST_NORMAL;
                    cnt_d   = '0;
                    code_d  = CODE_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_NORMAL;
            cnt_q   <= '0;
            code_q  <= CODE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign fault_detected = (state_q == ST_FAULT);
    assign fault_code     = code_q;

endmodule

// File: rtl/motor_fault_monitor.sv
// Multi-channel motor fault monitor: windowed averaging of current/speed
// samples feeding one debounced fault FSM per channel.
module motor_fault_monitor
    import motor_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2,
    parameter int DEB_CNT  = DEF_DEB_CNT
) (
    input  logic                clk,
    input  logic                rst_n,
    motor_sample_if.slave       smp,
    input  logic [DATA_W-1:0]   i_max,
    input  logic [DATA_W-1:0]   i_stall,
    input  logic [DATA_W-1:0]   spd_min,
    input  logic [DATA_W-1:0]   spd_max,
    input  logic [N_CH-1:0]     fault_clr,
    output logic                avg_valid,
    output logic [N_CH-1:0]     fault_detected,
    output logic [2*N_CH-1:0]   fault_code,
    output logic                fault_any
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [CNT_W-1:0]  win_cnt;
    logic              win_last;
    logic              win_done;
    logic [ACC_W-1:0]  acc_i [N_CH];
    logic [ACC_W-1:0]  acc_s [N_CH];
    logic [ACC_W-1:0]  sum_i [N_CH];
    logic [ACC_W-1:0]  sum_s [N_CH];
    // Stage averages separately so back-to-back windows cannot overwrite the
    // value the channel FSMs are still evaluating.
    logic [DATA_W-1:0] avg_stage_i [N_CH];
    logic [DATA_W-1:0] avg_stage_s [N_CH];
    logic [DATA_W-1:0] avg_out_i   [N_CH];
    logic [DATA_W-1:0] avg_out_s   [N_CH];

    assign win_last = smp.sample_valid && (win_cnt == WIN_LAST);

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            sum_i[c] = acc_i[c] + ACC_W'(smp.current_in[c*DATA_W +: DATA_W]);
            sum_s[c] = acc_s[c] + ACC_W'(smp.speed_in[c*DATA_W +: DATA_W]);
        end
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt   <= '0;
            win_done  <= 1'b0;
            avg_valid <= 1'b0;
            // NOTE: these arrays are small per-channel registers, not RAM, so resetting them is cheap and required.
            for (int c = 0; c < N_CH; c++) begin
                acc_i[c]       <= '0;
                acc_s[c]       <= '0;
                avg_stage_i[c] <= '0;
                avg_stage_s[c] <= '0;
                avg_out_i[c]   <= '0;
                avg_out_s[c]   <= '0;
            end
        end else begin
            win_done  <= win_last;
            avg_valid <= win_done;
            for (int c = 0; c < N_CH; c++) begin
                if (win_done) begin
                    avg_out_i[c] <= avg_stage_i[c];
                    avg_out_s[c] <= avg_stage_s[c];
                end
                if (win_last) begin
                    avg_stage_i[c] <= DATA_W'(sum_i[c] >> AVG_LOG2);
                    avg_stage_s[c] <= DATA_W'(sum_s[c] >> AVG_LOG2);
                    acc_i[c]       <= '0;
                    acc_s[c]       <= '0;
                end else if (smp.sample_valid) begin
                    acc_i[c] <= sum_i[c];
                    acc_s[c] <= sum_s[c];
                end
            end
            if (smp.sample_valid)
                win_cnt <= win_last ? '0 : win_cnt + CNT_W'(1);
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        motor_fault_chan #(
            .DATA_W  (DATA_W),
            .DEB_CNT (DEB_CNT)
        ) u_chan (
            .clk            (clk),
            .rst_n          (rst_n),
            .avg_valid      (avg_valid),
            .avg_i          (avg_out_i[c]),
            .avg_s          (avg_out_s[c]),
            .i_max          (i_max),
            .i_stall        (i_stall),
            .spd_min        (spd_min),
            .spd_max        (spd_max),
            .fault_clr      (fault_clr[c]),
            .fault_detected (fault_detected[c]),
            .fault_code     (fault_code[2*c +: 2])
        );
    end

    assign fault_any = |fault_detected;

endmodule
